// File: rtl/aes_mixw.sv
// AES MixColumns on one 32-bit state column (row 0 in the least-significant byte),
// with a combinational result and a one-cycle registered copy. Define AES_MIXW_INV_EN
// to add InvMixColumns, selected at run time by inv_i.
module aes_mixw (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] w_i,
  input  logic        valid_i,
  input  logic        inv_i,
  output logic [31:0] mixw_o,
  output logic [31:0] mixw_q_o,
  output logic        valid_o
);

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One output row of the forward matrix: 2*a ^ 3*b ^ c ^ d.
  function automatic logic [7:0] fwd_row(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
    return xtime(a) ^ (xtime(b) ^ b) ^ c ^ d;
  endfunction

  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] mixw_fwd;

  assign b0 = w_i[7:0];
  assign b1 = w_i[15:8];
  assign b2 = w_i[23:16];
  assign b3 = w_i[31:24];

  // Each row takes the column rotated so that its own byte comes first.
  assign mixw_fwd = {fwd_row(b3, b0, b1, b2),
                     fwd_row(b2, b3, b0, b1),
                     fwd_row(b1, b2, b3, b0),
                     fwd_row(b0, b1, b2, b3)};

`ifdef AES_MIXW_INV_EN
  // One output row of the inverse matrix: 14*a ^ 11*b ^ 13*c ^ 9*d, from chained xtime.
  function automatic logic [7:0] inv_row(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
    logic [7:0] a2, a4, a8, bb2, bb8, c4, c8, d8;
    a2  = xtime(a);
    a4  = xtime(a2);
    a8  = xtime(a4);
    bb2 = xtime(b);
    bb8 = xtime(xtime(bb2));
    c4  = xtime(xtime(c));
    c8  = xtime(c4);
    d8  = xtime(xtime(xtime(d)));
    return (a8 ^ a4 ^ a2) ^ (bb8 ^ bb2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
  endfunction

  logic [31:0] mixw_inv;

  assign mixw_inv = {inv_row(b3, b0, b1, b2),
                     inv_row(b2, b3, b0, b1),
                     inv_row(b1, b2, b3, b0),
                     inv_row(b0, b1, b2, b3)};

  assign mixw_o = inv_i ? mixw_inv : mixw_fwd;
`else
  logic unused_inv;

  assign unused_inv = inv_i;
  assign mixw_o     = mixw_fwd;
`endif

  logic [31:0] mixw_d, mixw_q;
  logic        valid_d, valid_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    mixw_d  = mixw_q;
    valid_d = valid_i;
    if (valid_i) begin
      mixw_d = mixw_o;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      mixw_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      mixw_q  <= mixw_d;
      valid_q <= valid_d;
    end
  end

  assign mixw_q_o = mixw_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_aes_mixw.sv
// Self-checking bench for aes_mixw: known vectors, randomized columns against a
// matrix-times-column GF(2^8) model, and the registered/streaming/reset behaviour.
module tb_aes_mixw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] w_i = 32'h0;
  logic        valid_i = 1'b0;
  logic        inv_i = 1'b0;
  logic [31:0] mixw_o;
  logic [31:0] mixw_q_o;
  logic        valid_o;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef AES_MIXW_INV_EN
  localparam bit INV_BUILT = 1'b1;
`else
  localparam bit INV_BUILT = 1'b0;
`endif

  aes_mixw dut (
    .clk      (clk),
    .rst      (rst),
    .w_i      (w_i),
    .valid_i  (valid_i),
    .inv_i    (inv_i),
    .mixw_o   (mixw_o),
    .mixw_q_o (mixw_q_o),
    .valid_o  (valid_o)
  );

  always #5 clk = ~clk;

  // Generic shift-and-add product in GF(2^8).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc = 8'h0;
    logic [7:0] x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return acc;
  endfunction

  // Circulant matrix times the column: r_k = sum_j coef[j] * b_(k+j).
  function automatic logic [31:0] model_mix(input logic [31:0] w, input bit inv);
    logic [7:0]  coef [4];
    logic [7:0]  r;
    logic [31:0] out = 32'h0;
    if (inv) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int k = 0; k < 4; k++) begin
      r = 8'h0;
      for (int j = 0; j < 4; j++) r ^= gf_mul(coef[j], w[8*((k+j)%4) +: 8]);
      out[8*k +: 8] = r;
    end
    return out;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; w_i = 32'h1a96de77;
    tick(); tick();
    n_cmp++;
    if (mixw_q_o !== 32'h0) begin
      n_bad++; $display("FAIL reset_q: got %h want 00000000", mixw_q_o);
    end
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o);
    end
    valid_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [31:0] vin [7] = '{32'h1a96de77, 32'he598271e, 32'h3b87db49, 32'h305dbfd4,
                             32'h455313db, 32'h00000000, 32'h01010101};
    logic [31:0] vexp [7] = '{32'he5b06b1b, 32'h4c260628, 32'hf1ca4d58, 32'he5816604,
                              32'hbca14d8e, 32'h00000000, 32'h01010101};
    inv_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      w_i = vin[i];
      #1;
      n_cmp++;
      if (mixw_o !== vexp[i]) begin
        n_bad++; $display("FAIL fwd_vec%0d: w=%h got %h want %h", i, vin[i], mixw_o, vexp[i]);
      end
    end
  endtask

  task automatic test_random_comb();
    logic [31:0] exp;
    for (int i = 0; i < 40; i++) begin
      w_i   = $urandom;
      inv_i = 1'($urandom_range(0, 1));
      exp   = model_mix(w_i, INV_BUILT && inv_i);
      #1;
      n_cmp++;
      if (mixw_o !== exp) begin
        n_bad++; $display("FAIL rand_comb: w=%h inv=%b got %h want %h", w_i, inv_i, mixw_o, exp);
      end
    end
    inv_i = 1'b0;
  endtask

  task automatic test_registered();
    valid_i = 1'b1; w_i = 32'h1a96de77;
    tick();
    n_cmp++;
    if (mixw_q_o !== 32'he5b06b1b || valid_o !== 1'b1) begin
      n_bad++; $display("FAIL reg_capture: got %h/%b want e5b06b1b/1", mixw_q_o, valid_o);
    end
    valid_i = 1'b0; w_i = 32'he598271e;
    tick();
    n_cmp++;
    if (mixw_q_o !== 32'he5b06b1b || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL reg_hold: got %h/%b want e5b06b1b/0", mixw_q_o, valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] exp;
    logic [31:0] last = 32'h0;
    logic [31:0] vin [4] = '{32'h1a96de77, 32'he598271e, 32'h3b87db49, 32'h305dbfd4};
    logic [31:0] vexp [4] = '{32'he5b06b1b, 32'h4c260628, 32'hf1ca4d58, 32'he5816604};
    for (int i = 0; i < 8; i++) begin
      valid_i = (i < 4) || (i >= 5 && i < 7);
      w_i     = (i < 4) ? vin[i] : $urandom;
      if (valid_i) q.push_back((i < 4) ? vexp[i] : model_mix(w_i, 1'b0));
      tick();
      if (valid_i) begin
        exp  = q.pop_front();
        last = exp;
      end else begin
        exp = last;
      end
      n_cmp++;
      if (mixw_q_o !== exp || valid_o !== valid_i) begin
        n_bad++;
        $display("FAIL stream%0d: got %h/%b want %h/%b", i, mixw_q_o, valid_o, exp, valid_i);
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    valid_i = 1'b1; w_i = 32'h3b87db49;
    tick();
    valid_i = 1'b1; w_i = $urandom; rst = 1'b1;
    exp = model_mix(w_i, 1'b0);
    tick();
    n_cmp++;
    if (mixw_q_o !== 32'h0 || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_regs: got %h/%b want 00000000/0", mixw_q_o, valid_o);
    end
    n_cmp++;
    if (mixw_o !== exp) begin
      n_bad++; $display("FAIL mid_reset_comb: got %h want %h", mixw_o, exp);
    end
    rst = 1'b0; valid_i = 1'b0;
    tick();
  endtask

  task automatic test_inverse();
    logic [31:0] x;
    inv_i = 1'b1;
`ifdef AES_MIXW_INV_EN
    w_i = 32'he5b06b1b; #1;
    n_cmp++;
    if (mixw_o !== 32'h1a96de77) begin
      n_bad++; $display("FAIL inv_vec0: got %h want 1a96de77", mixw_o);
    end
    w_i = 32'hbca14d8e; #1;
    n_cmp++;
    if (mixw_o !== 32'h455313db) begin
      n_bad++; $display("FAIL inv_vec1: got %h want 455313db", mixw_o);
    end
    for (int i = 0; i < 20; i++) begin
      x   = $urandom;
      w_i = model_mix(x, 1'b0);
      #1;
      n_cmp++;
      if (mixw_o !== x) begin
        n_bad++; $display("FAIL inv_roundtrip: w=%h got %h want %h", w_i, mixw_o, x);
      end
    end
    valid_i = 1'b1; w_i = 32'he5b06b1b;
    tick();
    n_cmp++;
    if (mixw_q_o !== 32'h1a96de77) begin
      n_bad++; $display("FAIL inv_reg: got %h want 1a96de77", mixw_q_o);
    end
    valid_i = 1'b0;
`else
    for (int i = 0; i < 4; i++) begin
      x   = $urandom;
      w_i = x;
      #1;
      n_cmp++;
      if (mixw_o !== model_mix(x, 1'b0)) begin
        n_bad++; $display("FAIL inv_ignored: w=%h got %h want %h", x, mixw_o, model_mix(x, 1'b0));
      end
    end
`endif
    inv_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random_comb();
    test_registered();
    test_back_to_back();
    test_reset_mid();
    test_inverse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_mixw.md
Name: aes_mixw

Overview:
AES MixColumns transform on one 32-bit state column. Sits in the AES round datapath after ShiftRows and before AddRoundKey.
- Combinational result for in-round chaining.
- One-cycle registered copy with a valid flag for pipelined datapaths.
- Inverse transform (InvMixColumns) available via compile-time option.

Parameters:
None. Width fixed at 32 bits, one column of four bytes.

Ports:
clk  input  1  clock; all flops on rising edge
rst  input  1  reset, synchronous, active-high
w_i  input  32  input column; byte k = w_i[8k+7:8k], k=0..3; byte 0 is state row 0
valid_i  input  1  qualifies w_i for the registered path
inv_i  input  1  1 = inverse transform; used only when AES_MIXW_INV_EN is defined, otherwise ignored
mixw_o  output  32  combinational MixColumns(w_i); byte k on [8k+7:8k]
mixw_q_o  output  32  registered result
valid_o  output  1  registered valid_i

Behaviour:
- Byte order: row 0 is the least-significant byte. Output byte k sits in the same lane as input byte k.
- xtime(a) = (a<<1)[7:0] XOR (a[7] ? 8'h1B : 8'h00), i.e. GF(2^8) with modulus x^8+x^4+x^3+x+1.
- 3·a = xtime(a) XOR a.
- Forward transform, indices mod 4, for k=0..3: r_k = 2·b_k ^ 3·b_(k+1) ^ b_(k+2) ^ b_(k+3).
- mixw_o is purely combinational from w_i (and inv_i). No clock dependency, zero latency, settles within the same cycle. mixw_o does not depend on rst or valid_i.
- Registered path on rising clk:
  - rst=1: mixw_q_o <= 32'h0 and valid_o <= 0. Reset has priority over valid_i.
  - Else, valid_i=1: mixw_q_o <= mixw_o.
  - Else: mixw_q_o holds its previous value.
  - valid_o <= valid_i every non-reset cycle.
- Latency: registered path is 1 cycle. Back-to-back valid inputs are accepted every cycle, with no stall and no backpressure.
- Reset asserted mid-stream: the flops clear on that edge and the in-flight result is discarded. The combinational output is unaffected.
- X on w_i propagates only to the affected outputs. No internal state other than the two registers.
- Arithmetic is XOR-only. No carries, no saturation.

Optional Feature:
Macro AES_MIXW_INV_EN.
- Defined: when inv_i=1, mixw_o = InvMixColumns(w_i): r_k = 14·b_k ^ 11·b_(k+1) ^ 13·b_(k+2) ^ 9·b_(k+3). The products are built from chained xtime. When inv_i=0, the forward transform as above. The registered path captures whichever transform is selected.
- Not defined: inv_i is ignored and only the forward transform is synthesized.

Test Plan:
- Forward vectors, combinational, checked 1 ns after drive, inv_i=0:
  - w_i=1a96de77 -> mixw_o=e5b06b1b
  - w_i=e598271e -> mixw_o=4c260628
  - w_i=3b87db49 -> mixw_o=f1ca4d58
  - w_i=305dbfd4 -> mixw_o=e5816604
- FIPS-197 column db,13,53,45: w_i=455313db -> mixw_o=bca14d8e. Also check the fixed points w_i=00000000 -> 00000000 and w_i=01010101 -> 01010101.
- Registered path: rst=1 for 2 cycles -> mixw_q_o=0 and valid_o=0. Then valid_i=1 with w_i=1a96de77 -> next edge mixw_q_o=e5b06b1b and valid_o=1. Then valid_i=0 with w_i=e598271e -> mixw_q_o holds e5b06b1b and valid_o=0.
- Streaming: the four forward vectors on consecutive cycles with valid_i=1 -> each expected value appears on mixw_q_o exactly one cycle later, with valid_o high for four cycles.
- Reset mid-stream: rst=1 in the same cycle as valid_i=1 -> after that edge mixw_q_o=0 and valid_o=0, while mixw_o still shows the combinational result.
- AES_MIXW_INV_EN defined, inv_i=1:
  - w_i=e5b06b1b -> mixw_o=1a96de77
  - w_i=bca14d8e -> mixw_o=455313db
  - Random 32-bit words: inverse(forward(x)) == x.
